// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcode constants and immediate-format enum shared by the decode stage.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

endpackage

// File: rtl/decode_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction, sign-extended to XLEN.
// Opcodes without an immediate produce zero and IMM_NONE.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type
);

    logic [31:0] imm32;

    // Pick the format from the opcode, then assemble the 32-bit immediate for it.
    always_comb begin
        imm_type = IMM_NONE;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm_type = IMM_I;
            OP_STORE:                 imm_type = IMM_S;
            OP_BRANCH:                imm_type = IMM_B;
            OP_LUI, OP_AUIPC:         imm_type = IMM_U;
            OP_JAL:                   imm_type = IMM_J;
            default:                  imm_type = IMM_NONE;
        endcase

        imm32 = '0;
        case (imm_type)
            IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm32 = {inst[31:12], 12'b0};
            IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: fetch -> execute decode with register file, immediate generation and a
// RAW scoreboard. One output register; sources with pending writers stall acceptance.
// Optional macro DECODE_BYPASS_EN: a write-back hitting a source in the same cycle
// clears that source's hazard and forwards wb_data straight into the captured operand.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RIDX = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [RIDX-1:0] out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_illegal,
    input  logic            wb_en,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0]             imm;
    logic [2:0]                  imm_type;
    logic [4:0]                  rs1_f, rs2_f, rd_f;
    logic [RIDX-1:0]             rs1, rs2;
    logic                        known, rs1_used, rs2_used, rd_wr, illegal;
    logic                        byp1, byp2, hazard, accept, issue;
    logic [XLEN-1:0]             rs1_val, rs2_val;
    logic [NREGS-1:0][XLEN-1:0]  rf_q;
    logic [NREGS-1:0]            busy_q, busy_d;
    logic                        out_valid_q, out_valid_d, out_rdwr_q;
    logic [XLEN-1:0]             out_pc_q, out_rs1_q, out_rs2_q, out_imm_q;
    logic [RIDX-1:0]             out_rd_q;
    logic [6:0]                  out_opcode_q;
    logic [2:0]                  out_funct3_q;
    logic                        out_funct7b5_q, out_illegal_q;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst     (in_inst),
        .imm      (imm),
        .imm_type (imm_type)
    );

    assign rs1_f = in_inst[19:15];
    assign rs2_f = in_inst[24:20];
    assign rd_f  = in_inst[11:7];
    assign rs1   = rs1_f[RIDX-1:0];
    assign rs2   = rs2_f[RIDX-1:0];

    // Classify the instruction: which register fields it reads/writes and whether it is legal.
    always_comb begin
        known = 1'b0;
        case (in_inst[6:0])
            OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR, OP_REG: known = 1'b1;
            default: known = 1'b0;
        endcase
        rs1_used = known && (imm_type != IMM_U) && (imm_type != IMM_J);
        rs2_used = (imm_type == IMM_S) || (imm_type == IMM_B) || (in_inst[6:0] == OP_REG);
        rd_wr    = known && (imm_type != IMM_S) && (imm_type != IMM_B);
        illegal  = !known
                || (rs1_used && int'(rs1_f) >= NREGS)
                || (rs2_used && int'(rs2_f) >= NREGS)
                || (rd_wr    && int'(rd_f)  >= NREGS);
    end

`ifdef DECODE_BYPASS_EN
    assign byp1 = wb_en && (wb_rd == rs1) && (rs1 != '0);
    assign byp2 = wb_en && (wb_rd == rs2) && (rs2 != '0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign rs1_val = byp1 ? wb_data : rf_q[rs1];
    assign rs2_val = byp2 ? wb_data : rf_q[rs2];

    // Illegal instructions skip the source checks so they can always drain.
    assign hazard   = !illegal && ((rs1_used && busy_q[rs1] && !byp1) ||
                                   (rs2_used && busy_q[rs2] && !byp2));
    assign in_ready = (!out_valid_q || out_ready) && !(in_valid && hazard) && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid_q && out_ready && !flush && out_rdwr_q && (out_rd_q != '0);

    // Register file; x0 is never written so it always reads back as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          rf_q <= '0;
        else if (wb_en && wb_rd != '0)     rf_q[wb_rd] <= wb_data;
    end

    // Scoreboard next state: write-back clears, issue sets, set wins on the same index.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) busy_d[wb_rd]    = 1'b0;
        if (issue) busy_d[out_rd_q] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    // Output valid: flush squashes, accept loads, a taken bundle empties the slot.
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (accept)    out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    // Output bundle register; payload only changes on accept so it holds while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q    <= 1'b0;
            out_rdwr_q     <= 1'b0;
            out_pc_q       <= '0;
            out_rs1_q      <= '0;
            out_rs2_q      <= '0;
            out_imm_q      <= '0;
            out_rd_q       <= '0;
            out_opcode_q   <= '0;
            out_funct3_q   <= '0;
            out_funct7b5_q <= 1'b0;
            out_illegal_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_rdwr_q     <= rd_wr && !illegal;
                out_pc_q       <= in_pc;
                out_rs1_q      <= rs1_val;
                out_rs2_q      <= rs2_val;
                out_imm_q      <= imm;
                out_rd_q       <= rd_f[RIDX-1:0];
                out_opcode_q   <= in_inst[6:0];
                out_funct3_q   <= in_inst[14:12];
                out_funct7b5_q <= in_inst[30];
                out_illegal_q  <= illegal;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_rs1_data = out_rs1_q;
    assign out_rs2_data = out_rs2_q;
    assign out_imm      = out_imm_q;
    assign out_rd       = out_rd_q;
    assign out_opcode   = out_opcode_q;
    assign out_funct3   = out_funct3_q;
    assign out_funct7b5 = out_funct7b5_q;
    assign out_illegal  = out_illegal_q;

endmodule
